// File: rtl/loader_pkg.sv
// Shared definitions for the imem program loader: frame header byte, FSM state
// encoding and the frame-length bound helper.
package loader_pkg;

  localparam logic [7:0] LOADER_HDR = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } loader_state_e;

  // A frame may hold at most 2**addr_width words.
  function automatic logic len_too_long(input logic [15:0] len, input int unsigned addr_width);
    return ({16'd0, len} > (32'd1 << addr_width));
  endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Packs payload bytes little-endian into 32-bit words and keeps the running XOR
// checksum of the payload. word_valid is raised on the byte that completes a word.
module loader_word_assembler
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic [7:0]  csum
);

  logic [23:0] lanes_q, lanes_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;

  // Byte lane shift, lane index and checksum update
  always_comb begin
    lanes_d    = lanes_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    word_valid = 1'b0;
    word_data  = {byte_data, lanes_q};
    if (clear) begin
      lanes_d = 24'd0;
      idx_d   = 2'd0;
      csum_d  = 8'd0;
    end else if (byte_valid) begin
      lanes_d    = {byte_data, lanes_q[23:8]};
      idx_d      = idx_q + 2'd1;
      csum_d     = csum_q ^ byte_data;
      word_valid = (idx_q == 2'd3);
    end else begin
      lanes_d = lanes_q;
    end
  end

  // Assembler state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      lanes_q <= 24'd0;
      idx_q   <= 2'd0;
      csum_q  <= 8'd0;
    end else begin
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
    end
  end

  assign csum = csum_q;

endmodule

// File: rtl/imem_program_loader.sv
// Framed byte-stream loader: fills imem from word 0 and holds the core in reset
// until a complete frame passes its XOR checksum.
module imem_program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_wren,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_data,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error
);

  loader_state_e         state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
  logic [31:0]           tmo_q, tmo_d;
  logic                  in_ready_q, in_ready_d;
  logic                  imem_wren_q, imem_wren_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_data_q, imem_data_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  load_done_q, load_done_d;
  logic                  load_error_q, load_error_d;

  logic        accept_s;
  logic        asm_clear_s;
  logic        asm_byte_s;
  logic        asm_word_valid_s;
  logic [31:0] asm_word_s;
  logic [7:0]  asm_csum_s;
  logic [15:0] len_full_s;
  logic        in_frame_s;

  assign accept_s    = in_valid & in_ready_q;
  assign asm_clear_s = accept_s & (state_q == ST_LEN_HI);
  assign asm_byte_s  = accept_s & (state_q == ST_DATA);
  assign len_full_s  = {in_data, len_q[7:0]};
  assign in_frame_s  = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                       (state_q == ST_DATA)   || (state_q == ST_CSUM);

  loader_word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (asm_clear_s),
    .byte_valid (asm_byte_s),
    .byte_data  (in_data),
    .word_valid (asm_word_valid_s),
    .word_data  (asm_word_s),
    .csum       (asm_csum_s)
  );

  // Frame FSM, length latch, word pointer and inter-byte timeout
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (in_data == LOADER_HDR)) state_d = ST_LEN_LO;
        else                                     state_d = ST_IDLE;
      end
      ST_LEN_LO: begin
        if (accept_s) begin
          len_d[7:0] = in_data;
          state_d    = ST_LEN_HI;
        end else begin
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_HI: begin
        if (accept_s) begin
          len_d[15:8] = in_data;
          ptr_d       = '0;
          if (len_too_long(len_full_s, ADDR_WIDTH)) state_d = ST_ERROR;
          else if (len_full_s == 16'd0)            state_d = ST_CSUM;
          else                                      state_d = ST_DATA;
        end else begin
          state_d = ST_LEN_HI;
        end
      end
      ST_DATA: begin
        if (asm_word_valid_s) begin
          ptr_d = ptr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
          if ((32'(ptr_q) + 32'd1) == 32'(len_q)) state_d = ST_CSUM;
          else                                     state_d = ST_DATA;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (accept_s) state_d = (in_data == asm_csum_s) ? ST_DONE : ST_ERROR;
        else          state_d = ST_CSUM;
      end
      ST_DONE, ST_ERROR: begin
        if (accept_s && (in_data == LOADER_HDR)) state_d = ST_LEN_LO;
        else                                     state_d = state_q;
      end
      default: state_d = ST_IDLE;
    endcase

    // Silence inside a frame overrides whatever the byte logic decided
    if (in_frame_s && !accept_s && (tmo_q >= 32'(TIMEOUT_CYCLES - 1))) begin
      state_d = ST_ERROR;
    end else begin
      state_d = state_d;
    end

    if (!in_frame_s || accept_s || (state_d != state_q)) tmo_d = 32'd0;
    else                                                 tmo_d = tmo_q + 32'd1;
  end

  // Next values of the registered outputs
  always_comb begin
    in_ready_d   = ~asm_word_valid_s;
    imem_wren_d  = asm_word_valid_s;
    imem_addr_d  = imem_addr_q;
    imem_data_d  = imem_data_q;
    if (asm_word_valid_s) begin
      imem_addr_d = ptr_q[ADDR_WIDTH-1:0];
      imem_data_d = asm_word_s;
    end else begin
      imem_addr_d = imem_addr_q;
    end
    cpu_reset_d  = (state_d != ST_DONE);
    load_done_d  = (state_d == ST_DONE);
    load_error_d = (state_d == ST_ERROR);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_q        <= 16'd0;
      ptr_q        <= '0;
      tmo_q        <= 32'd0;
      in_ready_q   <= 1'b0;
      imem_wren_q  <= 1'b0;
      imem_addr_q  <= '0;
      imem_data_q  <= 32'd0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      ptr_q        <= ptr_d;
      tmo_q        <= tmo_d;
      in_ready_q   <= in_ready_d;
      imem_wren_q  <= imem_wren_d;
      imem_addr_q  <= imem_addr_d;
      imem_data_q  <= imem_data_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_wren  = imem_wren_q;
  assign imem_addr  = imem_addr_q;
  assign imem_data  = imem_data_q;
  assign cpu_reset  = cpu_reset_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed + randomized bench for imem_program_loader: frames are built from word
// lists, expected imem writes and status come from the frame rules, not the RTL.
module tb_imem_program_loader;

  localparam int AW  = 4;
  localparam int TMO = 16;

  logic          clock;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          imem_wren;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          cpu_reset;
  logic          load_done;
  logic          load_error;

  imem_program_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_wren  (imem_wren),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int hs_bad = 0;
  int rd_idx = 0;
  bit hold_valid = 1'b0;
  logic rst_last = 1'b1;
  logic [AW+31:0] obs_q[$];
  logic [AW+31:0] exp_q[$];
  logic [31:0]    words_q[$];

  always @(posedge clock) rst_last <= reset;

  // Observe writes and the rule "in_ready low exactly when imem_wren is high"
  always @(negedge clock) begin
    if (imem_wren === 1'b1) obs_q.push_back({imem_addr, imem_data});
    if (!reset && !rst_last && (in_ready !== ~imem_wren)) hs_bad++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clock);
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $error("FAIL accept_bound observed no accept expected accept within 200 cycles");
    end
    @(posedge clock);
    #1;
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_wr_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = rd_idx; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) check({tag, "_wr"}, 64'(obs_q[i]), 64'(exp_q[i]));
    end
    rd_idx = exp_q.size();
  endtask

  // Sends words_q as one frame; bad corrupts the checksum byte
  task automatic send_frame(input string tag, input bit bad, input int gap_max);
    logic [7:0]  cs = 8'd0;
    logic [7:0]  b;
    logic [15:0] nl = 16'(words_q.size());
    send_byte(8'hA5);
    check({tag, "_hdr_cpu_reset"}, 64'(cpu_reset), 64'd1);
    check({tag, "_hdr_done"}, 64'(load_done), 64'd0);
    send_byte(nl[7:0]);
    send_byte(nl[15:8]);
    for (int i = 0; i < words_q.size(); i++) begin
      exp_q.push_back({AW'(i), words_q[i]});
      for (int l = 0; l < 4; l++) begin
        b  = words_q[i][8*l +: 8];
        cs = cs ^ b;
        send_byte(b);
        if (gap_max > 0) idle($urandom_range(0, gap_max));
      end
    end
    send_byte(bad ? (cs ^ 8'(($urandom_range(1, 255)))) : cs);
    check({tag, "_done"}, 64'(load_done), 64'(!bad));
    check({tag, "_error"}, 64'(load_error), 64'(bad));
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(bad));
    idle(2);
    compare_writes(tag);
  endtask

  task automatic load_frame1();
    words_q.delete();
    words_q.push_back(32'h00200013);
    words_q.push_back(32'h00400033);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_wren"}, 64'(imem_wren), 64'd0);
    check({tag, "_addr"}, 64'(imem_addr), 64'd0);
    check({tag, "_data"}, 64'(imem_data), 64'd0);
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
    check({tag, "_done"}, 64'(load_done), 64'd0);
    check({tag, "_error"}, 64'(load_error), 64'd0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    idle(3);
    check_reset_values("rst");
    reset = 1'b0;
    idle(2);

    // Garbage before the header, then frame 1
    send_byte(8'h00);
    send_byte(8'hFF);
    check("garbage_done", 64'(load_done), 64'd0);
    load_frame1();
    send_frame("f1", 1'b0, 0);

    // Bad checksum keeps words but not the core; good frame then recovers
    load_frame1();
    send_frame("f1bad", 1'b1, 1);
    load_frame1();
    send_frame("f1again", 1'b0, 1);

    // Empty frame
    words_q.delete();
    send_frame("n0", 1'b0, 0);

    // Inter-byte timeout
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    idle(8);
    check("tmo_early", 64'(load_error), 64'd0);
    idle(12);
    check("tmo_error", 64'(load_error), 64'd1);
    check("tmo_cpu_reset", 64'(cpu_reset), 64'd1);
    compare_writes("tmo");

    // Length bound: 2**AW words is allowed, one more is rejected
    send_byte(8'hA5);
    send_byte(8'(2**AW + 1));
    send_byte(8'h00);
    check("len_over_error", 64'(load_error), 64'd1);
    words_q.delete();
    for (int i = 0; i < 2**AW; i++) words_q.push_back($urandom);
    send_frame("len_max", 1'b0, 0);

    // Reset mid-frame discards the partial word
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    reset = 1'b1;
    idle(2);
    check_reset_values("midrst");
    reset = 1'b0;
    idle(1);
    load_frame1();
    send_frame("after_rst", 1'b0, 0);

    // Valid held high through a whole frame
    hold_valid = 1'b1;
    load_frame1();
    send_frame("hold", 1'b0, 0);
    hold_valid = 1'b0;
    in_valid   = 1'b0;
    idle(2);

    // Random frames
    for (int k = 0; k < 6; k++) begin
      words_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 5)); i++) words_q.push_back($urandom);
      send_frame("rand", ($urandom_range(0, 2) == 0), 2);
    end

    idle(4);
    compare_writes("final");
    check("handshake_violations", 64'(hs_bad), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
